// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scan front end: FSM states, column strobes and widths.
package keypad_pkg;

    localparam int ROW_W = 4;
    localparam int COL_W = 3;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } keypad_state_e;

    localparam logic [COL_W-1:0] COL0 = 3'b001;
    localparam logic [COL_W-1:0] COL1 = 3'b010;
    localparam logic [COL_W-1:0] COL2 = 3'b100;

    function automatic logic [COL_W-1:0] nextCol(input logic [COL_W-1:0] col);
        case (col)
            COL0:    return COL1;
            COL1:    return COL2;
            default: return COL0;
        endcase
    endfunction

    // A legal key press raises exactly one row line.
    function automatic logic isOneHot(input logic [ROW_W-1:0] rows);
        return (rows != '0) && ((rows & (rows - ROW_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer bringing the asynchronous keypad row lines into the clk domain.
module keypad_row_sync
    import keypad_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ROW_W-1:0] rows_i,
    output logic [ROW_W-1:0] rows_o
);

    logic [ROW_W-1:0] meta_q;
    logic [ROW_W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= rows_i;
            sync_q <= meta_q;
        end
    end

    assign rows_o = sync_q;

endmodule

// File: rtl/keypad_scan_driver.sv
// Column scanner with press/release debounce feeding stable (row, column) codes to the keypad decoder.
// Optional auto-repeat of key_event while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_driver
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_CNT   = 4,
    parameter int REPEAT_SAMPLES = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROW_W-1:0] row_in,
    output logic [COL_W-1:0] col_drv,
    output logic [ROW_W-1:0] row_out,
    output logic [COL_W-1:0] col_out,
    output logic             key_valid,
    output logic             key_event
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_SAMPLES < 1) begin : gBadParams
        $error("keypad_scan_driver: parameter out of range");
    end

    keypad_state_e    state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [COL_W-1:0] colDrv_q, colDrv_d;
    logic [ROW_W-1:0] candRow_q, candRow_d;
    logic [COL_W-1:0] candCol_q, candCol_d;
    logic [ROW_W-1:0] rowOut_q, rowOut_d;
    logic [COL_W-1:0] colOut_q, colOut_d;
    logic             keyValid_q, keyValid_d;
    logic             keyEvent_q, keyEvent_d;
    logic [ROW_W-1:0] rows;
    logic             samplePt;
    logic             rowsMatch;
    logic [CNT_W-1:0] cntInc;

    keypad_row_sync uRowSync (
        .clk    (clk),
        .rst    (rst),
        .rows_i (row_in),
        .rows_o (rows)
    );

    assign samplePt  = (div_q == DIV_LAST);
    assign rowsMatch = (rows == candRow_q);
    assign cntInc    = cnt_q + CNT_W'(1);
    assign div_d     = samplePt ? '0 : div_q + DIV_W'(1);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SAMPLES + 1);
    localparam logic [REP_W-1:0] REP_DONE = REP_W'(REPEAT_SAMPLES);
    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] repInc;
    assign repInc = rep_q + REP_W'(1);

    always_ff @(posedge clk) begin
        if (rst) rep_q <= '0;
        else     rep_q <= rep_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            div_q      <= '0;
            cnt_q      <= '0;
            colDrv_q   <= COL0;
            candRow_q  <= '0;
            candCol_q  <= '0;
            rowOut_q   <= '0;
            colOut_q   <= '0;
            keyValid_q <= 1'b0;
            keyEvent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            colDrv_q   <= colDrv_d;
            candRow_q  <= candRow_d;
            candCol_q  <= candCol_d;
            rowOut_q   <= rowOut_d;
            colOut_q   <= colOut_d;
            keyValid_q <= keyValid_d;
            keyEvent_q <= keyEvent_d;
        end
    end

    // Decisions are taken only at sample points; published codes change only on accept or release.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        colDrv_d   = colDrv_q;
        candRow_d  = candRow_q;
        candCol_d  = candCol_q;
        rowOut_d   = rowOut_q;
        colOut_d   = colOut_q;
        keyValid_d = keyValid_q;
        keyEvent_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d      = rep_q;
`endif
        if (samplePt) begin
            case (state_q)
                SCAN: begin
                    if (isOneHot(rows)) begin
                        candRow_d = rows;
                        candCol_d = colDrv_q;
                        cnt_d     = CNT_W'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            state_d    = HELD;
                            rowOut_d   = rows;
                            colOut_d   = colDrv_q;
                            keyValid_d = 1'b1;
                            keyEvent_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d      = '0;
`endif
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        colDrv_d = nextCol(colDrv_q);
                    end
                end
                DEBOUNCE: begin
                    if (!rowsMatch) begin
                        state_d  = SCAN;
                        colDrv_d = nextCol(colDrv_q);
                    end else if (cntInc == CNT_DONE) begin
                        state_d    = HELD;
                        cnt_d      = '0;
                        rowOut_d   = candRow_q;
                        colOut_d   = candCol_q;
                        keyValid_d = 1'b1;
                        keyEvent_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d      = '0;
`endif
                    end else begin
                        cnt_d = cntInc;
                    end
                end
                HELD: begin
                    if (rowsMatch) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (repInc == REP_DONE) begin
                            rep_d      = '0;
                            keyEvent_d = 1'b1;
                        end else begin
                            rep_d = repInc;
                        end
`endif
                    end else if (DEBOUNCE_CNT == 1) begin
                        state_d    = SCAN;
                        cnt_d      = '0;
                        colDrv_d   = nextCol(colDrv_q);
                        rowOut_d   = '0;
                        colOut_d   = '0;
                        keyValid_d = 1'b0;
                    end else begin
                        state_d = RELEASE;
                        cnt_d   = CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (rowsMatch) begin
                        state_d = HELD;
                        cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d   = '0;
`endif
                    end else if (cntInc == CNT_DONE) begin
                        state_d    = SCAN;
                        cnt_d      = '0;
                        colDrv_d   = nextCol(colDrv_q);
                        rowOut_d   = '0;
                        colOut_d   = '0;
                        keyValid_d = 1'b0;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

    assign col_drv   = colDrv_q;
    assign row_out   = rowOut_q;
    assign col_out   = colOut_q;
    assign key_valid = keyValid_q;
    assign key_event = keyEvent_q;

endmodule

// File: tb/tb_keypad_scan_driver.sv
// Directed bench for keypad_scan_driver with SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_SAMPLES=2.
// A small keypad model drives row_in from col_drv; build with KEYPAD_AUTOREPEAT_EN for the repeat variant.
module tb_keypad_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rowIn;
    logic [2:0] colDrv;
    logic [3:0] rowOut;
    logic [2:0] colOut;
    logic       keyValid;
    logic       keyEvent;

    logic       pressEn  = 1'b0;
    logic [3:0] pressRow = 4'b0000;
    logic [2:0] pressCol = 3'b000;

    int total = 0;
    int bad   = 0;
    int evCount = 0;
    int evStart;

    keypad_scan_driver #(
        .SCAN_DIV       (4),
        .DEBOUNCE_CNT   (3),
        .REPEAT_SAMPLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (rowIn),
        .col_drv   (colDrv),
        .row_out   (rowOut),
        .col_out   (colOut),
        .key_valid (keyValid),
        .key_event (keyEvent)
    );

    always #5 clk = ~clk;

    // The pressed key closes its row only while its own column is strobed.
    always_comb begin
        rowIn = (pressEn && ((colDrv & pressCol) != 3'b000)) ? pressRow : 4'b0000;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (keyEvent === 1'b1) evCount++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        total++; if (colDrv !== 3'b001) begin bad++; $display("[TB] FAIL reset_col_drv got=%b exp=001", colDrv); end
        total++; if (rowOut !== 4'b0000) begin bad++; $display("[TB] FAIL reset_row_out got=%b exp=0000", rowOut); end
        total++; if (colOut !== 3'b000) begin bad++; $display("[TB] FAIL reset_col_out got=%b exp=000", colOut); end
        total++; if (keyValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_key_valid got=%b exp=0", keyValid); end
        total++; if (keyEvent !== 1'b0) begin bad++; $display("[TB] FAIL reset_key_event got=%b exp=0", keyEvent); end
        rst = 1'b0;
        tick(3);
        total++; if (colDrv !== 3'b001) begin bad++; $display("[TB] FAIL rot_last001 got=%b exp=001", colDrv); end
        tick(1);
        total++; if (colDrv !== 3'b010) begin bad++; $display("[TB] FAIL rot_010 got=%b exp=010", colDrv); end
        tick(4);
        total++; if (colDrv !== 3'b100) begin bad++; $display("[TB] FAIL rot_100 got=%b exp=100", colDrv); end
        tick(4);
        total++; if (colDrv !== 3'b001) begin bad++; $display("[TB] FAIL rot_wrap001 got=%b exp=001", colDrv); end
    endtask

    task automatic test_press;
        pressRow = 4'b0010; pressCol = 3'b010; pressEn = 1'b1;
        evStart = evCount;
        tick(15);
        total++; if (keyValid !== 1'b0) begin bad++; $display("[TB] FAIL press_early_valid got=%b exp=0", keyValid); end
        total++; if (colDrv !== 3'b010) begin bad++; $display("[TB] FAIL press_debounce_col got=%b exp=010", colDrv); end
        tick(1);
        total++; if (keyValid !== 1'b1) begin bad++; $display("[TB] FAIL press_valid got=%b exp=1", keyValid); end
        total++; if (keyEvent !== 1'b1) begin bad++; $display("[TB] FAIL press_event got=%b exp=1", keyEvent); end
        total++; if (rowOut !== 4'b0010) begin bad++; $display("[TB] FAIL press_row_out got=%b exp=0010", rowOut); end
        total++; if (colOut !== 3'b010) begin bad++; $display("[TB] FAIL press_col_out got=%b exp=010", colOut); end
        tick(1);
        total++; if (keyEvent !== 1'b0) begin bad++; $display("[TB] FAIL press_event_width got=%b exp=0", keyEvent); end
        tick(20);
        total++; if (colDrv !== 3'b010) begin bad++; $display("[TB] FAIL press_col_frozen got=%b exp=010", colDrv); end
        total++; if (evCount - evStart !== 1) begin bad++; $display("[TB] FAIL press_event_count got=%0d exp=1", evCount - evStart); end
    endtask

    task automatic test_glitch;
        pressEn = 1'b0;
        tick(3);
        pressEn = 1'b1;
        total++; if (keyValid !== 1'b1) begin bad++; $display("[TB] FAIL glitch_valid_mid got=%b exp=1", keyValid); end
        tick(4);
        total++; if (keyValid !== 1'b1) begin bad++; $display("[TB] FAIL glitch_valid got=%b exp=1", keyValid); end
        total++; if (rowOut !== 4'b0010 || colOut !== 3'b010) begin bad++; $display("[TB] FAIL glitch_codes got=%b/%b exp=0010/010", rowOut, colOut); end
    endtask

    task automatic test_release;
        pressEn = 1'b0;
        evStart = evCount;
        tick(11);
        total++; if (keyValid !== 1'b1) begin bad++; $display("[TB] FAIL release_early got=%b exp=1", keyValid); end
        tick(1);
        total++; if (keyValid !== 1'b0) begin bad++; $display("[TB] FAIL release_valid got=%b exp=0", keyValid); end
        total++; if (rowOut !== 4'b0000 || colOut !== 3'b000) begin bad++; $display("[TB] FAIL release_codes got=%b/%b exp=0000/000", rowOut, colOut); end
        total++; if (colDrv !== 3'b100) begin bad++; $display("[TB] FAIL release_col_drv got=%b exp=100", colDrv); end
        total++; if (evCount !== evStart) begin bad++; $display("[TB] FAIL release_events got=%0d exp=0", evCount - evStart); end
    endtask

    task automatic test_bounce;
        pressRow = 4'b1000; pressCol = 3'b100; pressEn = 1'b1;
        evStart = evCount;
        tick(4);
        pressEn = 1'b0;
        tick(3);
        total++; if (colDrv !== 3'b100) begin bad++; $display("[TB] FAIL bounce_frozen got=%b exp=100", colDrv); end
        tick(1);
        total++; if (colDrv !== 3'b001) begin bad++; $display("[TB] FAIL bounce_advance got=%b exp=001", colDrv); end
        total++; if (keyValid !== 1'b0) begin bad++; $display("[TB] FAIL bounce_valid got=%b exp=0", keyValid); end
        total++; if (evCount !== evStart) begin bad++; $display("[TB] FAIL bounce_events got=%0d exp=0", evCount - evStart); end
    endtask

    task automatic test_multi_key;
        pressRow = 4'b0011; pressCol = 3'b001; pressEn = 1'b1;
        evStart = evCount;
        tick(4);
        total++; if (colDrv !== 3'b010) begin bad++; $display("[TB] FAIL multi_rotate got=%b exp=010", colDrv); end
        tick(11);
        total++; if (colDrv !== 3'b001) begin bad++; $display("[TB] FAIL multi_revisit got=%b exp=001", colDrv); end
        tick(1);
        total++; if (colDrv !== 3'b010) begin bad++; $display("[TB] FAIL multi_rotate2 got=%b exp=010", colDrv); end
        total++; if (keyValid !== 1'b0) begin bad++; $display("[TB] FAIL multi_valid got=%b exp=0", keyValid); end
        total++; if (evCount !== evStart) begin bad++; $display("[TB] FAIL multi_events got=%0d exp=0", evCount - evStart); end
    endtask

    task automatic test_autorepeat;
        int expEvents;
`ifdef KEYPAD_AUTOREPEAT_EN
        expEvents = 3;
`else
        expEvents = 1;
`endif
        pressRow = 4'b0001; pressCol = 3'b100; pressEn = 1'b1;
        evStart = evCount;
        tick(15);
        total++; if (keyValid !== 1'b0) begin bad++; $display("[TB] FAIL rep_early_valid got=%b exp=0", keyValid); end
        tick(1);
        total++; if (keyValid !== 1'b1 || keyEvent !== 1'b1) begin bad++; $display("[TB] FAIL rep_accept got=%b/%b exp=1/1", keyValid, keyEvent); end
        total++; if (rowOut !== 4'b0001 || colOut !== 3'b100) begin bad++; $display("[TB] FAIL rep_codes got=%b/%b exp=0001/100", rowOut, colOut); end
        tick(8);
`ifdef KEYPAD_AUTOREPEAT_EN
        total++; if (keyEvent !== 1'b1) begin bad++; $display("[TB] FAIL rep_first_repeat got=%b exp=1", keyEvent); end
`else
        total++; if (keyEvent !== 1'b0) begin bad++; $display("[TB] FAIL rep_no_repeat got=%b exp=0", keyEvent); end
`endif
        tick(12);
        total++; if (evCount - evStart !== expEvents) begin bad++; $display("[TB] FAIL rep_event_count got=%0d exp=%0d", evCount - evStart, expEvents); end
    endtask

    task automatic test_reset_held;
        total++; if (keyValid !== 1'b1) begin bad++; $display("[TB] FAIL rsth_pre_valid got=%b exp=1", keyValid); end
        rst = 1'b1;
        tick(1);
        total++; if (colDrv !== 3'b001) begin bad++; $display("[TB] FAIL rsth_col_drv got=%b exp=001", colDrv); end
        total++; if (rowOut !== 4'b0000 || colOut !== 3'b000) begin bad++; $display("[TB] FAIL rsth_codes got=%b/%b exp=0000/000", rowOut, colOut); end
        total++; if (keyValid !== 1'b0) begin bad++; $display("[TB] FAIL rsth_valid got=%b exp=0", keyValid); end
        total++; if (keyEvent !== 1'b0) begin bad++; $display("[TB] FAIL rsth_event got=%b exp=0", keyEvent); end
        rst = 1'b0;
        pressEn = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset;
        test_press;
        test_glitch;
        test_release;
        test_bounce;
        test_multi_key;
        test_autorepeat;
        test_reset_held;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
